// File: rtl/stop_watch_disp_pkg.sv
// Shared types and constants for the stopwatch display: FSM states, limits
// and active-low segment patterns {dp,g,f,e,d,c,b,a}.
package stop_watch_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_DIGITS  = 5;
    localparam int MS_MAX      = 999;
    localparam int SEC_MAX     = 59;
    localparam int SHIFT_STEPS = 10;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Double-dabble correction applied to one BCD digit before each shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to active-low 7-segment decoder with blank and
// decimal-point controls; codes 10-15 show blank.
module seg7_dec
    import stop_watch_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] seg_raw;

    always_comb begin
        seg_raw = SEG_BLANK;
        case (bcd)
            4'd0:    seg_raw = SEG_0;
            4'd1:    seg_raw = SEG_1;
            4'd2:    seg_raw = SEG_2;
            4'd3:    seg_raw = SEG_3;
            4'd4:    seg_raw = SEG_4;
            4'd5:    seg_raw = SEG_5;
            4'd6:    seg_raw = SEG_6;
            4'd7:    seg_raw = SEG_7;
            4'd8:    seg_raw = SEG_8;
            4'd9:    seg_raw = SEG_9;
            default: seg_raw = SEG_BLANK;
        endcase
    end

    always_comb begin
        seg = seg_raw;
        if (blank || (bcd > 4'd9)) begin
            seg = SEG_BLANK;
        end else if (dp) begin
            seg[7] = 1'b0;
        end
    end

endmodule

// File: rtl/stop_watch_disp.sv
// Stopwatch display: per-frame snapshot of ms/sec, iterative double-dabble
// to BCD, 5-digit multiplexed 7-segment scan. STOP_WATCH_DISP_BLANK_EN blanks leading s10 zero.
module stop_watch_disp
    import stop_watch_disp_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic        I_CLK,
    input  logic        I_RESN,
    input  logic [9:0]  I_TIMER_MS,
    input  logic [5:0]  I_TIMER_SEC,
    input  logic        I_HOLD,
    output logic [7:0]  O_SEG,
    output logic [4:0]  O_DIG,
    output logic [19:0] O_BCD,
    output logic        O_BUSY
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

    logic [PW-1:0] presc_reg;
    logic [2:0]    idx_reg;
    logic          presc_term;
    logic          frame_end;

    state_t        state_reg;
    logic [3:0]    shift_cnt_reg;
    logic [9:0]    snap_ms_reg;
    logic [5:0]    snap_sec_reg;
    logic [9:0]    ms_bin_reg;
    logic [9:0]    sec_bin_reg;
    logic [19:0]   acc_reg;
    logic [19:0]   acc_adj;
    logic [19:0]   bcd_reg;
    logic          busy_reg;
    logic          first_reg;
    logic          trigger;

    logic [9:0]    ms_sat;
    logic [5:0]    sec_sat;
    logic [9:0]    ms_load;
    logic [5:0]    sec_load;

    logic [3:0]    digit_arr [NUM_DIGITS];
    logic [3:0]    cur_digit;
    logic [4:0]    dig_next;
    logic          blank_next;
    logic          dp_next;
    logic [7:0]    seg_next;
    logic [7:0]    seg_reg;
    logic [4:0]    dig_reg;

    // ---------------- scan timing ----------------
    assign presc_term = (presc_reg == PRESC_LAST);
    assign frame_end  = presc_term && (idx_reg == IDX_LAST);

    always_ff @(posedge I_CLK) begin
        if (!I_RESN) begin
            presc_reg <= '0;
            idx_reg   <= '0;
        end else if (presc_term) begin
            presc_reg <= '0;
            idx_reg   <= (idx_reg == IDX_LAST) ? 3'd0 : (idx_reg + 3'd1);
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // ---------------- conversion ----------------
    assign ms_sat   = (I_TIMER_MS  > 10'(MS_MAX)) ? 10'(MS_MAX) : I_TIMER_MS;
    assign sec_sat  = (I_TIMER_SEC > 6'(SEC_MAX)) ? 6'(SEC_MAX) : I_TIMER_SEC;
    assign ms_load  = I_HOLD ? snap_ms_reg  : ms_sat;
    assign sec_load = I_HOLD ? snap_sec_reg : sec_sat;

    // first_reg gives the kick-off conversion right after reset release.
    assign trigger = first_reg || frame_end;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign acc_adj[gi*4 +: 4] = dd_adjust(acc_reg[gi*4 +: 4]);
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RESN) begin
            state_reg     <= IDLE;
            shift_cnt_reg <= '0;
            snap_ms_reg   <= '0;
            snap_sec_reg  <= '0;
            ms_bin_reg    <= '0;
            sec_bin_reg   <= '0;
            acc_reg       <= '0;
            bcd_reg       <= '0;
            busy_reg      <= 1'b0;
            first_reg     <= 1'b1;
        end else begin
            first_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    snap_ms_reg   <= ms_load;
                    snap_sec_reg  <= sec_load;
                    ms_bin_reg    <= ms_load;
                    sec_bin_reg   <= {4'd0, sec_load};
                    acc_reg       <= '0;
                    shift_cnt_reg <= '0;
                    busy_reg      <= 1'b1;
                    state_reg     <= SHIFT;
                end
                SHIFT: begin
                    // ms digits occupy acc[11:0], sec digits acc[19:12]; each path shifts in its own MSB.
                    acc_reg[11:0]  <= {acc_adj[10:0],  ms_bin_reg[9]};
                    acc_reg[19:12] <= {acc_adj[18:12], sec_bin_reg[9]};
                    ms_bin_reg     <= {ms_bin_reg[8:0],  1'b0};
                    sec_bin_reg    <= {sec_bin_reg[8:0], 1'b0};
                    if (shift_cnt_reg == 4'(SHIFT_STEPS - 1)) begin
                        state_reg <= DONE;
                    end else begin
                        shift_cnt_reg <= shift_cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    bcd_reg   <= acc_reg;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ---------------- digit mux and decode ----------------
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
        assign digit_arr[gi] = bcd_reg[gi*4 +: 4];
        assign dig_next[gi]  = (idx_reg != 3'(gi));
    end

    assign cur_digit = digit_arr[idx_reg];
    assign dp_next   = (idx_reg == 3'd3);

`ifdef STOP_WATCH_DISP_BLANK_EN
    assign blank_next = (idx_reg == IDX_LAST) && (bcd_reg[19:16] == 4'd0);
`else
    assign blank_next = 1'b0;
`endif

    seg7_dec u_seg7_dec (
        .bcd   (cur_digit),
        .blank (blank_next),
        .dp    (dp_next),
        .seg   (seg_next)
    );

    always_ff @(posedge I_CLK) begin
        if (!I_RESN) begin
            seg_reg <= SEG_BLANK;
            dig_reg <= '1;
        end else begin
            seg_reg <= seg_next;
            dig_reg <= dig_next;
        end
    end

    assign O_SEG  = seg_reg;
    assign O_DIG  = dig_reg;
    assign O_BCD  = bcd_reg;
    assign O_BUSY = busy_reg;

endmodule

// File: tb/tb_stop_watch_disp.sv
// Scoreboard bench for stop_watch_disp: stimulus queues expected O_BCD commits,
// a monitor pops and compares them on each busy falling edge.
module tb_stop_watch_disp;

    logic        clk = 1'b0;
    logic        resn;
    logic [9:0]  ms;
    logic [5:0]  sec;
    logic        hold;
    logic [7:0]  seg;
    logic [4:0]  dig;
    logic [19:0] bcd;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          commit_cnt = 0;
    logic [19:0] exp_q[$];

`ifdef STOP_WATCH_DISP_BLANK_EN
    localparam logic [7:0] DIG4_ZERO = 8'hFF;
`else
    localparam logic [7:0] DIG4_ZERO = 8'hC0;
`endif

    stop_watch_disp #(.SCAN_DIV(16)) dut (
        .I_CLK       (clk),
        .I_RESN      (resn),
        .I_TIMER_MS  (ms),
        .I_TIMER_SEC (sec),
        .I_HOLD      (hold),
        .O_SEG       (seg),
        .O_DIG       (dig),
        .O_BCD       (bcd),
        .O_BUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic wait_commit();
        int c0;
        bit seen;
        c0 = commit_cnt;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (commit_cnt != c0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL commit_timeout: no commit within 300 cycles");
        end
    endtask

    task automatic wait_dig(input logic [4:0] pat, input logic [7:0] exp, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dig == pat) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            check(name, {24'd0, seg}, {24'd0, exp});
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: digit %0b never enabled", name, pat);
        end
    endtask

    task automatic set_inputs(input logic [9:0] m, input logic [5:0] s, input logic h);
        #1;
        ms   = m;
        sec  = s;
        hold = h;
    endtask

    // Monitor: a commit is a busy 1->0 transition while out of reset.
    initial begin : monitor
        logic        prev_busy;
        int          busy_cnt;
        logic [19:0] exp;
        logic [19:0] last_exp;
        prev_busy = 1'b0;
        busy_cnt  = 0;
        last_exp  = '0;
        forever begin
            @(negedge clk);
            if (!resn) busy_cnt = 0;
            else if (busy) busy_cnt++;
            if (prev_busy && !busy && resn) begin
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    last_exp = exp;
                end else begin
                    exp = last_exp;
                end
                check("bcd_commit", {12'd0, bcd}, {12'd0, exp});
                check("busy_len", busy_cnt, 11);
                busy_cnt = 0;
                commit_cnt++;
            end
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        repeat (40000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        resn = 1'b0;
        ms   = 10'd345;
        sec  = 6'd12;
        hold = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_state", {seg, dig, bcd, busy}, {8'hFF, 5'h1F, 20'h0, 1'b0});
        end

        // Basic conversion and scan.
        exp_q.push_back(20'h12345);
        #1 resn = 1'b1;
        @(negedge clk);
        check("first_dig", {27'd0, dig}, {27'd0, 5'b11110});
        check("first_seg", {24'd0, seg}, 32'hC0);
        wait_commit();
        wait_dig(5'b11110, 8'h92, "seg_ms1_5");
        wait_dig(5'b10111, 8'h24, "seg_s1_2dp");
        wait_dig(5'b01111, 8'hF9, "seg_s10_1");

        // Saturation.
        wait_commit();
        exp_q.push_back(20'h59999);
        set_inputs(10'd1023, 6'd63, 1'b0);
        wait_commit();

        // Hold (lap) behaviour.
        exp_q.push_back(20'h05100);
        set_inputs(10'd100, 6'd5, 1'b0);
        wait_commit();
        for (int f = 0; f < 3; f++) exp_q.push_back(20'h05100);
        set_inputs(10'd200, 6'd7, 1'b1);
        for (int f = 0; f < 3; f++) wait_commit();
        exp_q.push_back(20'h07200);
        set_inputs(10'd200, 6'd7, 1'b0);
        wait_commit();

        // Reset during the 5th SHIFT cycle; the queued 05007 is for the restart.
        exp_q.push_back(20'h05007);
        set_inputs(10'd7, 6'd5, 1'b0);
        begin : wait_busy
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (busy) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                n_tests++;
                n_fail++;
                $display("FAIL busy_timeout: conversion never started");
            end
        end
        repeat (4) @(negedge clk);
        #1 resn = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bcd", {12'd0, bcd}, 32'd0);
        check("abort_dig", {27'd0, dig}, {27'd0, 5'h1F});
        repeat (2) @(negedge clk);
        #1 resn = 1'b1;
        @(negedge clk);
        check("restart_dig", {27'd0, dig}, {27'd0, 5'b11110});
        wait_commit();
        wait_dig(5'b11110, 8'hF8, "seg_ms1_7");
        wait_dig(5'b10111, 8'h12, "seg_s1_5dp");
        wait_dig(5'b01111, DIG4_ZERO, "seg_s10_lead0");

        repeat (5) @(negedge clk);
        check("queue_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stop_watch_disp.md
Name: stop_watch_disp

Overview:
- Display-side consumer of the stopwatch timer bus (I_TIMER_MS 0-999, I_TIMER_SEC 0-59).
- Snapshots both values once per scan frame and converts them to BCD with an iterative double-dabble FSM.
- Drives a 5-digit multiplexed 7-segment display in the format SS.mmm.
- Sits beside stop_watch_top and is wired directly to its O_TIMER_MS / O_TIMER_SEC outputs.

Parameters:
- SCAN_DIV, default 16: clocks each digit stays enabled. Must be >= 3, so that a frame of 5*SCAN_DIV clocks is longer than one 12-cycle conversion.

Ports:
- I_CLK  input  1  system clock.
- I_RESN  input  1  reset, synchronous, active-low.
- I_TIMER_MS  input  10  millisecond count from the timer.
- I_TIMER_SEC  input  6  second count from the timer.
- I_HOLD  input  1  1 = freeze the snapshot (lap display).
- O_SEG  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- O_DIG  output  5  digit enables, one-hot active-low; bit4 = seconds tens, bit0 = ms ones.
- O_BCD  output  20  committed display value {s10,s1,m100,m10,m1}, 4 bits each.
- O_BUSY  output  1  high while a conversion is in progress.

Behaviour:
- Reset (I_RESN=0 at a rising edge): O_SEG=8'hFF, O_DIG=5'h1F, O_BCD=0, O_BUSY=0. Prescaler, digit index and FSM clear.
- Reset mid-conversion aborts the conversion; nothing is committed.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At the terminal count, digit index advances 0->1->2->3->4->0.
  - O_DIG/O_SEG are registered and follow the index with 1-cycle latency.
  - First cycle after reset release: digit 0 is enabled, showing 0.
- Conversion trigger: the cycle after reset release, and at every frame end (index==4 and prescaler terminal).
- FSM: IDLE -> LOAD -> SHIFT (10 cycles) -> DONE -> IDLE.
  - IDLE: O_BUSY=0, waits for a trigger.
  - LOAD:
    - If I_HOLD=0, snapshot the inputs; if I_HOLD=1, keep the previous snapshot.
    - Saturate: ms>999 -> 999, sec>59 -> 59.
    - O_BUSY=1.
  - SHIFT: double-dabble runs in parallel on two paths, 10-bit ms -> 3 digits and 6-bit sec zero-extended -> 2 digits. Each iteration adds 3 to every digit >=5, then shifts.
  - DONE: commits O_BCD atomically, so the display never mixes old and new digits.
  - Total conversion: 12 cycles from trigger to O_BCD update.
  - A trigger that arrives while busy is ignored (cannot occur when SCAN_DIV>=3).
- Segment decode (active-low, dp off) for BCD 0-9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - Digit 3 (seconds ones) has dp on (bit7=0), e.g. "2." = 8'h24.
  - Codes 10-15 decode to blank (FF).
- Inputs change asynchronously to the frame; only the LOAD-cycle sample matters.

Optional Feature:
- Macro STOP_WATCH_DISP_BLANK_EN.
- Defined: leading-zero blanking. Digit 4 shows blank (O_SEG=FF) when s10==0. All other digits are always lit.
- Undefined: every digit always shows its value, including a leading 0.
- O_BCD is identical in both cases.

Decomposition:
- Shared package stop_watch_disp_pkg (Verilog header), holding:
  - FSM state encodings: IDLE, LOAD, SHIFT, DONE.
  - NUM_DIGITS=5, MS_MAX=999, SEC_MAX=59.
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
- One sub-module: seg7_dec, a combinational 4-bit BCD + blank + dp to 8-bit segment pattern decoder, instantiated once on the muxed digit.

Test Plan:
- Hold I_RESN=0 for 10 cycles -> O_SEG=FF, O_DIG=1F, O_BCD=0, O_BUSY=0 throughout.
- ms=345, sec=12, SCAN_DIV=16 -> after the first commit O_BCD=20'h12345. While O_DIG=5'b11110, O_SEG=92; while O_DIG=5'b10111, O_SEG=24.
- ms=1023, sec=63 -> O_BCD=20'h59999 (saturation). O_BUSY is high for exactly 11 cycles per conversion (LOAD, SHIFT, DONE).
- ms=100, sec=5 committed, then I_HOLD=1 and ms=200, sec=7 over 3 frames -> O_BCD stays 20'h05100. Release I_HOLD -> next commit gives 20'h07200.
- Assert I_RESN=0 during the 5th SHIFT cycle -> next edge O_BUSY=0, O_BCD=0, O_DIG=1F. After release, the first conversion restarts cleanly.
- sec=5, ms=7 -> digit 4 shows O_SEG=FF with STOP_WATCH_DISP_BLANK_EN and C0 without; O_BCD=20'h05007 in both builds.
